// File: rtl/aw_rr_xbar.sv
// AXI write-address router: registered round-robin grant across masters, address decode to one
// slave, per-master outstanding-write throttle released by B handshakes, and a routing pulse for W.

module aw_os_cnt (
   input  logic       clk,
   input  logic       rstn,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] cnt
);
   // Simultaneous inc and dec cancel; decrement saturates at zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                            cnt <= '0;
      else if (inc && !dec && cnt != 4'hF)  cnt <= cnt + 4'd1;
      else if (dec && !inc && cnt != 4'h0)  cnt <= cnt - 4'd1;
   end
endmodule

module aw_rr_xbar #(
   parameter int NUM_MASTERS = 3,
   parameter int NUM_SLAVES  = 7,
   parameter int ID_BITS     = 4,
   parameter int ADDR_BITS   = 32,
   parameter int LEN_BITS    = 4,
   parameter int SIZE_BITS   = 3,
   parameter int BURST_BITS  = 2,
   parameter logic [NUM_SLAVES*ADDR_BITS-1:0] SLAVE_BASE = {
      32'h0006_0000, 32'h0005_0000, 32'h0004_0000, 32'h0003_0000,
      32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_BITS-1:0] SLAVE_MASK = {7{32'hFFFF_0000}},
   parameter int DEFAULT_SLAVE   = NUM_SLAVES - 1,
   parameter int MAX_OUTSTANDING = 1,
   localparam int MID_BITS = $clog2(NUM_MASTERS),
   localparam int SID_BITS = $clog2(NUM_SLAVES)
) (
   input  logic                                              clk,
   input  logic                                              rstn,
   input  logic [NUM_MASTERS-1:0][ID_BITS-1:0]               AWID_M,
   input  logic [NUM_MASTERS-1:0][ADDR_BITS-1:0]             AWADDR_M,
   input  logic [NUM_MASTERS-1:0][LEN_BITS-1:0]              AWLEN_M,
   input  logic [NUM_MASTERS-1:0][SIZE_BITS-1:0]             AWSIZE_M,
   input  logic [NUM_MASTERS-1:0][BURST_BITS-1:0]            AWBURST_M,
   input  logic [NUM_MASTERS-1:0]                            AWVALID_M,
   output logic [NUM_MASTERS-1:0]                            AWREADY_M,
   input  logic [NUM_MASTERS-1:0]                            BVALID_M,
   input  logic [NUM_MASTERS-1:0]                            BREADY_M,
   output logic [NUM_SLAVES-1:0][ID_BITS+MID_BITS-1:0]       AWID_S,
   output logic [NUM_SLAVES-1:0][ADDR_BITS-1:0]              AWADDR_S,
   output logic [NUM_SLAVES-1:0][LEN_BITS-1:0]               AWLEN_S,
   output logic [NUM_SLAVES-1:0][SIZE_BITS-1:0]              AWSIZE_S,
   output logic [NUM_SLAVES-1:0][BURST_BITS-1:0]             AWBURST_S,
   output logic [NUM_SLAVES-1:0]                             AWVALID_S,
   input  logic [NUM_SLAVES-1:0]                             AWREADY_S,
   output logic                                              aw_hs,
   output logic [MID_BITS-1:0]                               aw_hs_mst,
   output logic [SID_BITS-1:0]                               aw_hs_slv
);
   typedef struct packed {
      logic [MID_BITS+ID_BITS-1:0] id;
      logic [ADDR_BITS-1:0]        addr;
      logic [LEN_BITS-1:0]         len;
      logic [SIZE_BITS-1:0]        size;
      logic [BURST_BITS-1:0]       burst;
   } aw_req_t;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                        state;
   logic [MID_BITS-1:0]           grant_idx, rr_ptr, pick, rr_next;
   logic                          any_elig, hs;
   logic [SID_BITS-1:0]           dec;
   logic [NUM_MASTERS-1:0]        elig;
   logic [NUM_MASTERS-1:0][3:0]   os_cnt;
   aw_req_t                       req;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_os
      aw_os_cnt u_os (
         .clk  (clk),
         .rstn (rstn),
         .inc  (hs && (grant_idx == MID_BITS'(i))),
         .dec  (BVALID_M[i] & BREADY_M[i]),
         .cnt  (os_cnt[i])
      );
      assign elig[i] = AWVALID_M[i] && (os_cnt[i] < 4'(MAX_OUTSTANDING));
   end

   // Walk downward so the closest eligible master at or above rr_ptr is the last to be written.
   always_comb begin
      any_elig = 1'b0;
      pick     = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         int m;
         m = int'(rr_ptr) + k;
         if (m >= NUM_MASTERS) m = m - NUM_MASTERS;
         if (elig[m]) begin
            any_elig = 1'b1;
            pick     = MID_BITS'(m);
         end
      end
   end

   always_comb begin
      dec = SID_BITS'(DEFAULT_SLAVE);
      for (int s = NUM_SLAVES - 1; s >= 0; s--)
         if ((AWADDR_M[grant_idx] & SLAVE_MASK[s*ADDR_BITS +: ADDR_BITS]) ==
             SLAVE_BASE[s*ADDR_BITS +: ADDR_BITS])
            dec = SID_BITS'(s);
   end

   assign hs      = (state == GRANT) && AWVALID_M[grant_idx] && AWREADY_S[dec];
   assign rr_next = (grant_idx == MID_BITS'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      req       = '0;
      AWVALID_S = '0;
      AWREADY_M = '0;
      if (state == GRANT) begin
         req.id                = {grant_idx, AWID_M[grant_idx]};
         req.addr              = AWADDR_M[grant_idx];
         req.len               = AWLEN_M[grant_idx];
         req.size              = AWSIZE_M[grant_idx];
         req.burst             = AWBURST_M[grant_idx];
         AWVALID_S[dec]        = AWVALID_M[grant_idx];
         AWREADY_M[grant_idx]  = AWREADY_S[dec];
      end
   end

   for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_bcast
      assign AWID_S[s]    = req.id;
      assign AWADDR_S[s]  = req.addr;
      assign AWLEN_S[s]   = req.len;
      assign AWSIZE_S[s]  = req.size;
      assign AWBURST_S[s] = req.burst;
   end

   assign aw_hs     = hs;
   assign aw_hs_mst = hs ? grant_idx : '0;
   assign aw_hs_slv = hs ? dec : '0;

   // Grant is held until the handshake; no re-arbitration while in GRANT.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            IDLE: if (any_elig) begin
               grant_idx <= pick;
               state     <= GRANT;
            end
            GRANT: if (hs) begin
               rr_ptr <= rr_next;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aw_rr_xbar.sv
// Bench for aw_rr_xbar: single-request table, directed multi-cycle sequences, and random traffic
// checked every cycle against a transaction-level reference model.

module tb_aw_rr_xbar;
   localparam int NM = 3, NS = 7, IDB = 4, AB = 32, LB = 4, SZB = 3, BB = 2, MB = 2, SB = 3;

   logic clk = 1'b0;
   logic rstn;
   logic [NM-1:0][IDB-1:0] awid_m;
   logic [NM-1:0][AB-1:0]  awaddr_m;
   logic [NM-1:0][LB-1:0]  awlen_m;
   logic [NM-1:0][SZB-1:0] awsize_m;
   logic [NM-1:0][BB-1:0]  awburst_m;
   logic [NM-1:0]          awvalid_m, awready_m, bvalid_m, bready_m;
   logic [NS-1:0][IDB+MB-1:0] awid_s;
   logic [NS-1:0][AB-1:0]  awaddr_s;
   logic [NS-1:0][LB-1:0]  awlen_s;
   logic [NS-1:0][SZB-1:0] awsize_s;
   logic [NS-1:0][BB-1:0]  awburst_s;
   logic [NS-1:0]          awvalid_s, awready_s;
   logic                   aw_hs;
   logic [MB-1:0]          aw_hs_mst;
   logic [SB-1:0]          aw_hs_slv;

   always #5 clk = ~clk;

   aw_rr_xbar dut (
      .clk(clk), .rstn(rstn),
      .AWID_M(awid_m), .AWADDR_M(awaddr_m), .AWLEN_M(awlen_m), .AWSIZE_M(awsize_m),
      .AWBURST_M(awburst_m), .AWVALID_M(awvalid_m), .AWREADY_M(awready_m),
      .BVALID_M(bvalid_m), .BREADY_M(bready_m),
      .AWID_S(awid_s), .AWADDR_S(awaddr_s), .AWLEN_S(awlen_s), .AWSIZE_S(awsize_s),
      .AWBURST_S(awburst_s), .AWVALID_S(awvalid_s), .AWREADY_S(awready_s),
      .aw_hs(aw_hs), .aw_hs_mst(aw_hs_mst), .aw_hs_slv(aw_hs_slv)
   );

   int n_vec = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: which master owns the channel (-1 = none), rotation start, outstanding counts.
   int m_own, m_ptr, m_os[NM];
   logic m_hs;

   function automatic int slave_of(input logic [AB-1:0] a);
      int hi;
      hi = int'(a >> 16);
      return (hi < 6) ? hi : 6;
   endfunction

   task automatic m_reset();
      m_own = -1; m_ptr = 0; m_hs = 1'b0;
      for (int i = 0; i < NM; i++) m_os[i] = 0;
   endtask

   task automatic mchk();
      logic [NS-1:0] evs; logic [NM-1:0] erd; int d;
      logic [NS-1:0][IDB+MB-1:0] eid; logic [NS-1:0][AB-1:0] ead;
      logic [NS-1:0][LB-1:0] eln; logic [NS-1:0][SZB-1:0] esz; logic [NS-1:0][BB-1:0] ebu;
      evs = '0; erd = '0; eid = '0; ead = '0; eln = '0; esz = '0; ebu = '0; d = 0; m_hs = 1'b0;
      if (m_own >= 0) begin
         d = slave_of(awaddr_m[m_own]);
         evs[d] = awvalid_m[m_own];
         erd[m_own] = awready_s[d];
         m_hs = awvalid_m[m_own] & awready_s[d];
         for (int s = 0; s < NS; s++) begin
            eid[s] = {MB'(m_own), awid_m[m_own]};
            ead[s] = awaddr_m[m_own];
            eln[s] = awlen_m[m_own];
            esz[s] = awsize_m[m_own];
            ebu[s] = awburst_m[m_own];
         end
      end
      chk("awvalid_s", awvalid_s, evs);
      chk("awready_m", awready_m, erd);
      chk("aw_hs", aw_hs, m_hs);
      chk("aw_hs_mst", aw_hs_mst, m_hs ? m_own : 0);
      chk("aw_hs_slv", aw_hs_slv, m_hs ? d : 0);
      chk("awid_s", awid_s, eid);
      chk("awaddr_s", awaddr_s, ead);
      chk("len_size_burst", {awlen_s, awsize_s, awburst_s}, {eln, esz, ebu});
   endtask

   task automatic mstep();
      if (m_own < 0) begin
         for (int k = NM - 1; k >= 0; k--) begin
            int m;
            m = (m_ptr + k) % NM;
            if (awvalid_m[m] && m_os[m] < 1) m_own = m;
         end
      end else if (m_hs) begin
         m_os[m_own]++;
         m_ptr = (m_own + 1) % NM;
         m_own = -1;
      end
      for (int i = 0; i < NM; i++)
         if (bvalid_m[i] && bready_m[i] && m_os[i] > 0) m_os[i]--;
   endtask

   // Entered just after a falling edge with inputs already set.
   task automatic cyc();
      #1 mchk();
      @(posedge clk);
      mstep();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      awvalid_m = '0; bvalid_m = '0; bready_m = '0; awready_s = '1;
      awid_m = '0; awaddr_m = '0; awlen_m = '0; awsize_m = '0; awburst_m = '0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   typedef struct { int mst; logic [AB-1:0] addr; logic [IDB-1:0] id; int slv; } vec_t;
   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [NS-1:0] oh; logic [NM-1:0] mo; int r;
      tbl[0] = '{1, 32'h0001_0000, 4'h3, 1};
      tbl[1] = '{0, 32'h0000_1234, 4'hA, 0};
      tbl[2] = '{2, 32'h0005_FFFF, 4'h7, 5};
      tbl[3] = '{2, 32'hFFFF_FFF0, 4'hF, 6};
      tbl[4] = '{1, 32'h0003_8000, 4'h1, 3};
      tbl[5] = '{0, 32'h0006_0000, 4'h5, 6};

      do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_awvalid_s", awvalid_s, 0);
      chk("rst_awready_m", awready_m, 0);
      chk("rst_hs", {aw_hs, aw_hs_mst, aw_hs_slv}, 0);
      chk("rst_payload", {awid_s, awaddr_s}, 0);
      @(negedge clk);
      rstn = 1'b1;

      foreach (tbl[j]) begin
         do_reset();
         awvalid_m[tbl[j].mst] = 1'b1;
         awaddr_m[tbl[j].mst]  = tbl[j].addr;
         awid_m[tbl[j].mst]    = tbl[j].id;
         cyc();
         #1;
         oh = '0; oh[tbl[j].slv] = 1'b1;
         mo = '0; mo[tbl[j].mst] = 1'b1;
         chk("tbl_awvalid_s", awvalid_s, oh);
         chk("tbl_awready_m", awready_m, mo);
         chk("tbl_hs", aw_hs, 1);
         chk("tbl_hs_mst", aw_hs_mst, tbl[j].mst);
         chk("tbl_hs_slv", aw_hs_slv, tbl[j].slv);
         chk("tbl_awid_s", awid_s[tbl[j].slv], {MB'(tbl[j].mst), tbl[j].id});
         cyc();
         awvalid_m = '0;
         cyc();
      end

      // Round robin with B returned every cycle so no master is throttled.
      do_reset();
      for (int i = 0; i < NM; i++) awaddr_m[i] = AB'(i) << 16;
      awvalid_m = '1; bvalid_m = '1; bready_m = '1;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("rr_hs", aw_hs, c % 2);
         if (c % 2 == 1) chk("rr_mst", aw_hs_mst, (c / 2) % 3);
         cyc();
      end

      // Outstanding lock: M0 blocked until the cycle after its B handshake.
      do_reset();
      awaddr_m[0] = 32'h0000_0100; awaddr_m[1] = 32'h0001_0100; awvalid_m = 3'b011;
      for (int c = 0; c < 8; c++) begin
         bvalid_m = (c == 5) ? 3'b001 : 3'b000;
         bready_m = bvalid_m;
         #1;
         chk("lock_hs", aw_hs, (c == 1 || c == 3 || c == 7));
         chk("lock_mst", aw_hs_mst, (c == 3) ? 1 : 0);
         cyc();
      end

      // Slave stall: S2 not ready for 5 GRANT cycles.
      do_reset();
      bvalid_m = '1; bready_m = '1;
      awaddr_m[1] = 32'h0002_0010; awaddr_m[2] = 32'h0002_0020; awvalid_m = 3'b110;
      awready_s = 7'h7B;
      cyc();
      for (int c = 1; c <= 6; c++) begin
         if (c == 6) awready_s = '1;
         #1;
         chk("stall_awvalid_s", awvalid_s, 7'h04);
         chk("stall_addr", awaddr_s[2], 32'h0002_0010);
         chk("stall_hs", aw_hs, c == 6);
         cyc();
      end
      cyc();
      #1;
      chk("stall_second_mst", {aw_hs, aw_hs_mst}, {1'b1, 2'd2});
      cyc();

      // Reset while M1 holds the grant and M0 has a write outstanding.
      do_reset();
      awaddr_m[0] = 32'h0000_0000; awaddr_m[1] = 32'h0001_0000; awvalid_m = 3'b011;
      repeat (3) cyc();
      rstn = 1'b0;
      #1;
      chk("midrst_awvalid_s", awvalid_s, 0);
      chk("midrst_awready_m", awready_m, 0);
      chk("midrst_hs", {aw_hs, aw_hs_mst, aw_hs_slv}, 0);
      chk("midrst_payload", {awid_s, awaddr_s}, 0);
      m_reset();
      @(negedge clk);
      rstn = 1'b1;
      cyc();
      #1;
      chk("midrst_first_grant", {aw_hs, aw_hs_mst}, {1'b1, 2'd0});
      cyc();

      // Random traffic, including valid drops mid-grant and B at zero count.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NM; i++) begin
            r = $urandom_range(0, 8);
            awaddr_m[i]  = (r < 7) ? {16'(r), 16'($urandom)} : 32'($urandom);
            awid_m[i]    = 4'($urandom);
            awlen_m[i]   = 4'($urandom);
            awsize_m[i]  = 3'($urandom);
            awburst_m[i] = 2'($urandom);
         end
         awvalid_m = 3'($urandom) | 3'($urandom);
         awready_s = 7'($urandom) | 7'($urandom);
         bvalid_m  = 3'($urandom) & 3'($urandom);
         bready_m  = 3'($urandom) | 3'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
